// File: rtl/tpu_pkg.sv
// Shared TPU command layout, sequencer state encoding and command packing helper.
// Pure declarations: no latency, no flow control.
// Command bit layout matches the control unit's 64-bit command word.
package tpu_pkg;

  localparam int W          = 16;
  localparam int CMD_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr_d;
    logic [CMD_ADDR_W-1:0] addr_c;
    logic [CMD_ADDR_W-1:0] addr_b;
    logic [CMD_ADDR_W-1:0] addr_a;
    logic [7:0]            len_n;
    logic [7:0]            len_k;
    logic [7:0]            len_m;
  } command_t;

  function automatic command_t pack_cmd(
    input logic [CMD_ADDR_W-1:0] d,
    input logic [CMD_ADDR_W-1:0] c,
    input logic [CMD_ADDR_W-1:0] b,
    input logic [CMD_ADDR_W-1:0] a,
    input logic [7:0]            ln,
    input logic [7:0]            lk,
    input logic [7:0]            lm
  );
    command_t cmd;
    cmd.addr_d = d;
    cmd.addr_c = c;
    cmd.addr_b = b;
    cmd.addr_a = a;
    cmd.len_n  = ln;
    cmd.len_k  = lk;
    cmd.len_m  = lm;
    return cmd;
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile index walker (m outer, n middle, k inner) with add-only address registers.
// Current tile fields come straight from registers; advance takes effect next cycle.
// No flow control of its own: steps only when the owner pulses advance.
module tile_addr_gen #(
  parameter int ADDR_WIDTH = tpu_pkg::CMD_ADDR_W,
  parameter int W          = tpu_pkg::W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic [ADDR_WIDTH-1:0] base_d,
  input  logic [4:0]            tiles_m,
  input  logic [4:0]            tiles_k,
  input  logic [4:0]            tiles_n,
  input  logic [4:0]            last_m,
  input  logic [4:0]            last_k,
  input  logic [4:0]            last_n,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic [ADDR_WIDTH-1:0] addr_d,
  output logic [7:0]            len_m,
  output logic [7:0]            len_k,
  output logic [7:0]            len_n,
  output logic                  k_first,
  output logic                  k_last,
  output logic                  last_tile
);

  localparam int                    WLOG   = $clog2(W);
  localparam logic [ADDR_WIDTH-1:0] W_STEP = ADDR_WIDTH'(W);
  localparam logic [7:0]            W_LEN  = 8'(W);

  logic [4:0]            m_idx, n_idx, k_idx;
  logic [4:0]            tm, tk, tn;
  logic [4:0]            lm, lk, ln;
  logic [ADDR_WIDTH-1:0] base_b_r, tk_step, tn_step;
  logic [ADDR_WIDTH-1:0] a_row_base, a_addr, b_col_base, b_addr, c_addr, d_addr;
  logic                  m_last, n_last;

  function automatic logic [4:0] edge_len(input logic [4:0] v);
    return (v == 5'd0) ? 5'd16 : v;
  endfunction

  assign m_last    = (m_idx == tm - 5'd1);
  assign n_last    = (n_idx == tn - 5'd1);
  assign k_last    = (k_idx == tk - 5'd1);
  assign k_first   = (k_idx == 5'd0);
  assign last_tile = m_last & n_last & k_last;

  // k > 0 accumulates onto the partial sum already written to D
  assign addr_a = a_addr;
  assign addr_b = b_addr;
  assign addr_c = k_first ? c_addr : d_addr;
  assign addr_d = d_addr;
  assign len_m  = m_last ? {3'b000, lm} : W_LEN;
  assign len_k  = k_last ? {3'b000, lk} : W_LEN;
  assign len_n  = n_last ? {3'b000, ln} : W_LEN;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_idx      <= '0;
      n_idx      <= '0;
      k_idx      <= '0;
      tm         <= '0;
      tk         <= '0;
      tn         <= '0;
      lm         <= '0;
      lk         <= '0;
      ln         <= '0;
      base_b_r   <= '0;
      tk_step    <= '0;
      tn_step    <= '0;
      a_row_base <= '0;
      a_addr     <= '0;
      b_col_base <= '0;
      b_addr     <= '0;
      c_addr     <= '0;
      d_addr     <= '0;
    end else if (load) begin
      m_idx      <= '0;
      n_idx      <= '0;
      k_idx      <= '0;
      tm         <= tiles_m;
      tk         <= tiles_k;
      tn         <= tiles_n;
      lm         <= edge_len(last_m);
      lk         <= edge_len(last_k);
      ln         <= edge_len(last_n);
      base_b_r   <= base_b;
      tk_step    <= ADDR_WIDTH'(tiles_k) << WLOG;
      tn_step    <= ADDR_WIDTH'(tiles_n) << WLOG;
      a_row_base <= base_a;
      a_addr     <= base_a;
      b_col_base <= base_b;
      b_addr     <= base_b;
      c_addr     <= base_c;
      d_addr     <= base_d;
    end else if (advance) begin
      if (!k_last) begin
        k_idx  <= k_idx + 5'd1;
        a_addr <= a_addr + W_STEP;
        b_addr <= b_addr + tn_step;
      end else begin
        k_idx  <= '0;
        c_addr <= c_addr + W_STEP;
        d_addr <= d_addr + W_STEP;
        if (!n_last) begin
          n_idx      <= n_idx + 5'd1;
          a_addr     <= a_row_base;
          b_col_base <= b_col_base + W_STEP;
          b_addr     <= b_col_base + W_STEP;
        end else begin
          n_idx      <= '0;
          m_idx      <= m_idx + 5'd1;
          a_row_base <= a_row_base + tk_step;
          a_addr     <= a_row_base + tk_step;
          b_col_base <= base_b_r;
          b_addr     <= base_b_r;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Expands one GEMM job into 64-bit tile commands and tracks their retirement.
// Job accept to first cmd_valid: 1 cycle; then up to one command per cycle.
// cmd_valid/cmd_data hold until cmd_ready; k>0 tiles wait for all prior tiles to retire.
module gemm_tile_sequencer #(
  parameter int ADDR_WIDTH      = tpu_pkg::CMD_ADDR_W,
  parameter int W               = tpu_pkg::W,
  parameter int MAX_OUTSTANDING = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_base_a,
  input  logic [ADDR_WIDTH-1:0] job_base_b,
  input  logic [ADDR_WIDTH-1:0] job_base_c,
  input  logic [ADDR_WIDTH-1:0] job_base_d,
  input  logic [4:0]            job_tiles_m,
  input  logic [4:0]            job_tiles_k,
  input  logic [4:0]            job_tiles_n,
  input  logic [4:0]            job_last_m,
  input  logic [4:0]            job_last_k,
  input  logic [4:0]            job_last_n,
  output logic                  cmd_valid,
  output logic [63:0]           cmd_data,
  input  logic                  cmd_ready,
  input  logic                  done_irq,
  output logic                  busy,
  output logic                  job_done,
  output logic                  protocol_err
);

  import tpu_pkg::*;

  if (ADDR_WIDTH != CMD_ADDR_W) begin : g_bad_addr_width
    $error("gemm_tile_sequencer: ADDR_WIDTH must be 10 to fit the 64-bit command");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max_outstanding
    $error("gemm_tile_sequencer: MAX_OUTSTANDING must fit the 3-bit counter (1..7)");
  end

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  seq_state_t            state;
  logic [2:0]            outstanding, out_next;
  logic                  job_hs, cmd_hs, zero_job, kf_next, issue_ok;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c, addr_d;
  logic [7:0]            len_m, len_k, len_n;
  logic                  k_first, k_last, last_tile;
  command_t              cmd_word;

  assign job_hs   = job_valid & job_ready;
  assign cmd_hs   = cmd_valid & cmd_ready;
  assign zero_job = (job_tiles_m == 5'd0) | (job_tiles_k == 5'd0) | (job_tiles_n == 5'd0);

  // Look at the post-edge count and tile so a retirement re-opens issue on the next cycle
  always_comb begin
    out_next = outstanding;
    if (cmd_hs && !done_irq)
      out_next = outstanding + 3'd1;
    else if (!cmd_hs && done_irq && outstanding != 3'd0)
      out_next = outstanding - 3'd1;
    kf_next  = cmd_hs ? k_last : k_first;
    issue_ok = (kf_next || out_next == 3'd0) && (out_next < MAX_OUT);
  end

  tile_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .W          (W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (job_hs),
    .advance   (cmd_hs),
    .base_a    (job_base_a),
    .base_b    (job_base_b),
    .base_c    (job_base_c),
    .base_d    (job_base_d),
    .tiles_m   (job_tiles_m),
    .tiles_k   (job_tiles_k),
    .tiles_n   (job_tiles_n),
    .last_m    (job_last_m),
    .last_k    (job_last_k),
    .last_n    (job_last_n),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_c    (addr_c),
    .addr_d    (addr_d),
    .len_m     (len_m),
    .len_k     (len_k),
    .len_n     (len_n),
    .k_first   (k_first),
    .k_last    (k_last),
    .last_tile (last_tile)
  );

  // Fields are flop outputs, so the word is steady for as long as it is offered
  assign cmd_word = pack_cmd(addr_d, addr_c, addr_b, addr_a, len_n, len_k, len_m);
  assign cmd_data = cmd_valid ? cmd_word : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_valid    <= 1'b0;
      job_ready    <= 1'b1;
      busy         <= 1'b0;
      job_done     <= 1'b0;
      protocol_err <= 1'b0;
      outstanding  <= '0;
    end else begin
      job_done    <= 1'b0;
      outstanding <= out_next;
      if (done_irq && outstanding == 3'd0)
        protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (job_hs) begin
            outstanding <= '0;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
            if (zero_job) begin
              state    <= DONE;
              job_done <= 1'b1;
            end else begin
              state     <= ISSUE;
              cmd_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_hs && last_tile) begin
            cmd_valid <= 1'b0;
            state     <= DRAIN;
          end else if (!cmd_valid || cmd_hs) begin
            cmd_valid <= issue_ok;
          end
        end
        DRAIN: begin
          if (outstanding == 3'd0) begin
            state    <= DONE;
            job_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          job_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: command scoreboard from an address-formula model,
// plus cycle-exact checks of issue, stall, drain and reset behaviour.
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [9:0]  job_base_a, job_base_b, job_base_c, job_base_d;
  logic [4:0]  job_tiles_m, job_tiles_k, job_tiles_n;
  logic [4:0]  job_last_m, job_last_k, job_last_n;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready;
  logic        done_irq;
  logic        busy;
  logic        job_done;
  logic        protocol_err;

  gemm_tile_sequencer #(
    .ADDR_WIDTH      (10),
    .W               (16),
    .MAX_OUTSTANDING (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_base_a   (job_base_a),
    .job_base_b   (job_base_b),
    .job_base_c   (job_base_c),
    .job_base_d   (job_base_d),
    .job_tiles_m  (job_tiles_m),
    .job_tiles_k  (job_tiles_k),
    .job_tiles_n  (job_tiles_n),
    .job_last_m   (job_last_m),
    .job_last_k   (job_last_k),
    .job_last_n   (job_last_n),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .done_irq     (done_irq),
    .busy         (busy),
    .job_done     (job_done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          hs_count    = 0;
  logic [63:0] sb[$];
  logic        stall_prev  = 1'b0;
  logic [63:0] prev_data   = '0;

  task automatic check1(input string tag, input logic obs, input logic want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, want);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int want);
    vectors++;
    assert (obs == want) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected commands straight from the closed-form address equations
  task automatic push_job(input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc,
                          input logic [9:0] bd, input int tm, input int tk, input int tn,
                          input int lm, input int lk, input int ln);
    logic [9:0] a, b, c, d;
    logic [7:0] lenm, lenk, lenn;
    for (int m = 0; m < tm; m++)
      for (int n = 0; n < tn; n++)
        for (int k = 0; k < tk; k++) begin
          a    = 10'(ba + (m * tk + k) * 16);
          b    = 10'(bb + (k * tn + n) * 16);
          d    = 10'(bd + (m * tn + n) * 16);
          c    = (k == 0) ? 10'(bc + (m * tn + n) * 16) : d;
          lenm = 8'((m == tm - 1) ? ((lm == 0) ? 16 : lm) : 16);
          lenk = 8'((k == tk - 1) ? ((lk == 0) ? 16 : lk) : 16);
          lenn = 8'((n == tn - 1) ? ((ln == 0) ? 16 : ln) : 16);
          sb.push_back({d, c, b, a, lenn, lenk, lenm});
        end
  endtask

  task automatic start_job(input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc,
                           input logic [9:0] bd, input int tm, input int tk, input int tn,
                           input int lm, input int lk, input int ln);
    check1("job_ready_idle", job_ready, 1'b1);
    job_base_a  = ba;
    job_base_b  = bb;
    job_base_c  = bc;
    job_base_d  = bd;
    job_tiles_m = 5'(tm);
    job_tiles_k = 5'(tk);
    job_tiles_n = 5'(tn);
    job_last_m  = 5'(lm);
    job_last_k  = 5'(lk);
    job_last_n  = 5'(ln);
    push_job(ba, bb, bc, bd, tm, tk, tn, lm, lk, ln);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done_irq = 1'b1;
    tick();
    done_irq = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!cmd_valid && n < budget) begin
      tick();
      n++;
    end
    check1(tag, cmd_valid, 1'b1);
  endtask

  task automatic wait_job_done(input int budget);
    int n = 0;
    while (!job_done && n < budget) begin
      tick();
      n++;
    end
    check1("job_done_seen", job_done, 1'b1);
    tick();
    check1("job_ready_back", job_ready, 1'b1);
    checki("sb_drained", sb.size(), 0);
  endtask

  // Handshake scoreboard and hold-while-stalled monitor
  always @(negedge clk) begin
    logic [63:0] want;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check1("stall_valid_hold", cmd_valid, 1'b1);
        check64("stall_data_hold", cmd_data, prev_data);
      end
      if (cmd_valid && cmd_ready) begin
        hs_count++;
        vectors++;
        assert (sb.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_cmd: got %h expected no command", cmd_data);
        end
        if (sb.size() > 0) begin
          want = sb.pop_front();
          check64("cmd_data", cmd_data, want);
        end
      end
      stall_prev = cmd_valid && !cmd_ready;
      prev_data  = cmd_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h0;
    logic [63:0] held;
    rst = 1'b1; job_valid = 1'b0; cmd_ready = 1'b0; done_irq = 1'b0;
    job_base_a = '0; job_base_b = '0; job_base_c = '0; job_base_d = '0;
    job_tiles_m = '0; job_tiles_k = '0; job_tiles_n = '0;
    job_last_m = '0; job_last_k = '0; job_last_n = '0;
    tick(); tick(); tick();

    check1("rst_cmd_valid", cmd_valid, 1'b0);
    check64("rst_cmd_data", cmd_data, 64'd0);
    check1("rst_job_ready", job_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_job_done", job_done, 1'b0);
    check1("rst_protocol_err", protocol_err, 1'b0);
    rst = 1'b0;
    tick();

    // Single-tile job: exact command word and drain timing
    cmd_ready = 1'b1;
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 1, 1, 1, 16, 16, 16);
    check1("t1_first_valid", cmd_valid, 1'b1);
    check1("t1_busy", busy, 1'b1);
    check1("t1_job_ready_low", job_ready, 1'b0);
    check64("t1_word", cmd_data, {10'h300, 10'h200, 10'h100, 10'h000, 8'd16, 8'd16, 8'd16});
    tick();
    check1("t1_single_cmd", cmd_valid, 1'b0);
    pulse_done();
    check1("t1_done_not_early", job_done, 1'b0);
    tick();
    check1("t1_done_u_plus_2", job_done, 1'b1);
    check1("t1_ready_not_yet", job_ready, 1'b0);
    tick();
    check1("t1_done_one_cycle", job_done, 1'b0);
    check1("t1_ready_u_plus_3", job_ready, 1'b1);
    checki("t1_sb_drained", sb.size(), 0);

    // K accumulation: second tile waits for the first to retire
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 1, 2, 1, 16, 16, 16);
    check1("t2_first_valid", cmd_valid, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check1("t2_k_stall", cmd_valid, 1'b0);
      tick();
    end
    pulse_done();
    check1("t2_resume_after_done", cmd_valid, 1'b1);
    tick();
    pulse_done();
    wait_job_done(20);

    // 2x1x2 grid with short edge tiles; last_k of 0 means a full tile
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 2, 1, 2, 5, 0, 9);
    check1("t3_first_valid", cmd_valid, 1'b1);
    h0 = hs_count;
    for (int i = 0; i < 4; i++) tick();
    checki("t3_back_to_back", hs_count - h0, 4);
    check1("t3_stream_end", cmd_valid, 1'b0);
    for (int i = 0; i < 4; i++) pulse_done();
    wait_job_done(20);

    // Backpressure, outstanding limit and simultaneous issue/retire
    cmd_ready = 1'b0;
    start_job(10'h040, 10'h080, 10'h0C0, 10'h100, 1, 1, 10, 16, 16, 16);
    check1("t4_first_valid", cmd_valid, 1'b1);
    held = cmd_data;
    for (int i = 0; i < 5; i++) tick();
    check1("t4_stall_valid", cmd_valid, 1'b1);
    check64("t4_stall_data", cmd_data, held);
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check1("t4_limit_reached", cmd_valid, 1'b0);
    tick();
    check1("t4_limit_held", cmd_valid, 1'b0);
    done_irq = 1'b1;
    tick();
    check1("t4_resume", cmd_valid, 1'b1);
    tick();
    done_irq = 1'b0;
    check1("t4_simul_unchanged", cmd_valid, 1'b1);
    tick();
    check1("t4_refilled", cmd_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      pulse_done();
      tick();
    end
    for (int i = 0; i < 6; i++) pulse_done();
    wait_job_done(20);
    check1("t4_no_protocol_err", protocol_err, 1'b0);

    // Retirement with nothing outstanding
    pulse_done();
    check1("t5_protocol_err_set", protocol_err, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check1("t5_protocol_err_sticky", protocol_err, 1'b1);

    // Reset in the middle of issue
    cmd_ready = 1'b0;
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 1, 1, 4, 16, 16, 16);
    wait_valid("t6_valid_before_rst", 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check1("t6_cmd_valid", cmd_valid, 1'b0);
    check1("t6_busy", busy, 1'b0);
    check1("t6_job_ready", job_ready, 1'b1);
    check64("t6_cmd_data", cmd_data, 64'd0);
    check1("t6_protocol_err_cleared", protocol_err, 1'b0);
    cmd_ready = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("t6_no_cmd_after_rst", cmd_valid, 1'b0);
    end
    checki("t6_no_handshakes", hs_count - h0, 0);

    // Zero-count job completes without commands
    h0 = hs_count;
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 2, 0, 2, 16, 16, 16);
    check1("t7_job_done", job_done, 1'b1);
    check1("t7_no_valid", cmd_valid, 1'b0);
    tick();
    check1("t7_done_pulse_end", job_done, 1'b0);
    check1("t7_job_ready", job_ready, 1'b1);
    checki("t7_no_commands", hs_count - h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Upstream feeder for the TPU control unit. Accepts one GEMM job described in 16×16 tile units and expands it into a stream of 64-bit tile commands on the control unit's `cmd_valid`/`cmd_data`/`cmd_ready` port. It tracks outstanding commands through the control unit's `done_irq` pulse and stalls K-accumulation tiles until their partial sums have been written back. It signals job completion once every issued tile has retired.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10, SRAM row address width. Must be 10 so the command packs into 64 bits; other values fail an elaboration assertion.
- `W`, default 16, tile edge (systolic array width). Each tile occupies W SRAM rows.
- `MAX_OUTSTANDING`, default 6, issued-but-not-retired command limit.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `job_valid` in 1: job request.
- `job_ready` out 1: high only in IDLE.
- `job_base_a` / `job_base_b` / `job_base_c` / `job_base_d` in ADDR_WIDTH each: tile-array base addresses.
- `job_tiles_m` / `job_tiles_k` / `job_tiles_n` in 5 each: tile counts, 0..16.
- `job_last_m` / `job_last_k` / `job_last_n` in 5 each: edge-tile size, 1..16. Value 0 is treated as 16.
- `cmd_valid` out 1: command to the control unit.
- `cmd_data` out 64: `[63:54]` addr_d, `[53:44]` addr_c, `[43:34]` addr_b, `[33:24]` addr_a, `[23:16]` len_n, `[15:8]` len_k, `[7:0]` len_m.
- `cmd_ready` in 1: control unit FIFO not full.
- `done_irq` in 1: one pulse per retired command.
- `busy` out 1: state != IDLE.
- `job_done` out 1: single-cycle completion pulse.
- `protocol_err` out 1: sticky; set by `done_irq` while outstanding == 0.

## Operation
- Loop order is m outer, n middle, k inner. Tile (m,n,k) uses these addresses, all modulo 2^ADDR_WIDTH:
  - A = base_a + (m·tiles_k + k)·W
  - B = base_b + (k·tiles_n + n)·W
  - D = base_d + (m·tiles_n + n)·W
  - C = base_c + (m·tiles_n + n)·W when k == 0; otherwise C = D (accumulate onto the previous partial).
- Addresses are generated incrementally with no multipliers. Registers: `a_row_base`, `a_addr`, `b_col_base`, `b_addr`, `c_addr`, `d_addr`.
  - k step: a += W, b += tiles_n·W.
  - n step: a = a_row_base, b_col_base += W, b = b_col_base, c += W, d += W.
  - m step: a_row_base += tiles_k·W, b_col_base = base_b.
- Lengths are 8-bit zero-extended. len_m = last_m on the final m tile, else W. len_k and len_n follow the same rule.
- `outstanding` counter (3 bits):
  - +1 on a command handshake.
  - −1 on `done_irq`.
  - Unchanged when both occur in the same cycle.
  - Saturates at 0 on an erroneous `done_irq`.
- FSM states:
  - IDLE: on job handshake, latch the job and clear the counters. If any tile count is 0, go to DONE. Otherwise go to ISSUE.
  - ISSUE: `cmd_valid` = (k == 0 || outstanding == 0) && outstanding < MAX_OUTSTANDING. On handshake, advance the tile indices. After the last tile, go to DRAIN.
  - DRAIN: wait for outstanding == 0, then go to DONE.
  - DONE: pulse `job_done` for one cycle, then go to IDLE.

## Timing
- Reset values: `cmd_valid`=0, `cmd_data`=0, `job_ready`=1, `busy`=0, `job_done`=0, `protocol_err`=0, outstanding=0, state IDLE.
- Reset mid-job aborts immediately. No further commands are issued.
- Job accepted at cycle t → first `cmd_valid` at t+1. Peak rate is one command per cycle.
- `cmd_data` is registered and stays stable while `cmd_valid && !cmd_ready`. `cmd_valid` never drops without a handshake, except through reset.
- A dependency stall is evaluated before `cmd_valid` rises. The next tile is presented only after the stall clears.
- Final `done_irq` at cycle u → `job_done` at u+2 (DRAIN then DONE). `job_ready` returns at u+3.
- Zero-count job accepted at t → `job_done` at t+1, no commands issued.

## Structure
- Shared package (`tpu_pkg`) holds:
  - `command_t`, the same packed layout as the control unit's command.
  - Constant W.
  - Function `pack_cmd()`.
- Sub-module: `tile_addr_gen`, holding the index counters, incremental address registers and last-tile flags. Handshake/advance in, current tile fields plus `last_tile` and `k_first` out.
- FSM and outstanding counter live at top level.

## Test plan
- Job with bases 0x000/0x100/0x200/0x300, tiles 1/1/1, last 16/16/16 → one command, `cmd_data` = {0x300, 0x200, 0x100, 0x000, 16, 16, 16}. `job_done` 2 cycles after `done_irq`.
- Tiles m=1, k=2, n=1 → cmd0 {d 0x300, c 0x200, b 0x100, a 0x000}. cmd1 {d 0x300, c 0x300, b 0x110, a 0x010}. `cmd_valid` stays low until cmd0's `done_irq`.
- Tiles m=2, k=1, n=2, last 5/16/9 → A/B/D sequence:
  - A: 0x000, 0x000, 0x010, 0x010.
  - B: 0x100, 0x110, 0x100, 0x110.
  - D: 0x300, 0x310, 0x320, 0x330.
  - len_n: 16, 9, 16, 9. len_m: 16, 16, 5, 5.
- `cmd_ready` held low 5 cycles with `done_irq` withheld → `cmd_data` stable throughout. Issue stops at 6 outstanding. It resumes one cycle after a `done_irq`.
- Simultaneous handshake and `done_irq` → outstanding unchanged. `done_irq` while idle → `protocol_err` = 1 and stays 1.
- `rst` asserted mid-ISSUE → next cycle `cmd_valid`=0, `busy`=0, `job_ready`=1. A tiles_k=0 job → `job_done` pulse with zero commands.
